button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 131 +++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state stability FSM,
// registered level output, press/release strobes and a wrapping press counter.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_WIDTH       = 8,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn,
  output logic                 pressed,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output logic [CNT_WIDTH-1:0] press_count
);

  localparam int                STAB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "not pressed"; the synchronizer resets to it.
  localparam logic              RELEASED_LVL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_t               state_q, state_d;
  logic [STAB_W-1:0]    stab_q, stab_d;
  logic                 pressed_q, pressed_d;
  logic                 press_pulse_q, press_pulse_d;
  logic                 release_pulse_q, release_pulse_d;
  logic [CNT_WIDTH-1:0] press_count_q, press_count_d;
  logic                 b_s;

  // Synchronized button, normalised so that 1 always means pressed.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    b_s     = sync2_q ^ ACTIVE_LOW;
  end

  // State register: every flop in the block, reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q         <= RELEASED_LVL;
      sync2_q         <= RELEASED_LVL;
      state_q         <= IDLE;
      stab_q          <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_count_q   <= '0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      stab_q          <= stab_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_count_q   <= press_count_d;
    end
  end

  // Next state: a candidate level must survive DEBOUNCE_CYCLES counted edges.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      IDLE: begin
        if (b_s) begin
          state_d = PRESS_WAIT;
          stab_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!b_s) begin
          state_d = IDLE;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = HELD;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      HELD: begin
        if (!b_s) begin
          state_d = RELEASE_WAIT;
          stab_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (b_s) begin
          state_d = HELD;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = IDLE;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register with it.
  always_comb begin
    pressed_d       = (state_d == HELD) || (state_d == RELEASE_WAIT);
    press_pulse_d   = (state_q == PRESS_WAIT) && (state_d == HELD);
    release_pulse_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    press_count_d   = press_count_q;
    if (press_pulse_d) begin
      press_count_d = press_count_q + 1'b1;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = press_count_q;

endmodule
